// File: rtl/hsv_core_branch_unit_param.sv
// Parametrised branch execution unit.
// Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR over a two-stage pipeline
// (s1: compare + target, s2: next PC / link / mispredict). A small output FIFO
// sits behind s2. Because s1/s2 never stall, input acceptance is credit based:
// an instruction is taken only when the FIFO has room for everything already
// in flight plus the new one.
module hsv_core_branch_unit_param #(
    parameter int XLEN           = 32,
    parameter int TAG_W          = 5,
    parameter int OUT_DEPTH      = 2,
    parameter int MISALIGN_CHECK = 1
) (
    input  logic             clk_core,
    input  logic             rst_core_n,
    input  logic             flush_req,
    output logic             flush_ack,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_next_pc,
    output logic [XLEN-1:0]  out_link,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_exception
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);
    localparam logic [XLEN-1:0]  LSB_CLR  = ~XLEN'(1);

    localparam logic [3:0] OP_BEQ  = 4'd0;
    localparam logic [3:0] OP_BNE  = 4'd1;
    localparam logic [3:0] OP_BLT  = 4'd4;
    localparam logic [3:0] OP_BGE  = 4'd5;
    localparam logic [3:0] OP_BLTU = 4'd6;
    localparam logic [3:0] OP_BGEU = 4'd7;
    localparam logic [3:0] OP_JAL  = 4'd8;
    localparam logic [3:0] OP_JALR = 4'd9;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  next_pc;
        logic [XLEN-1:0]  link;
        logic             taken;
        logic             mispredict;
        logic             exception;
    } entry_t;

    // FIFO pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic signed [XLEN-1:0] rs1_s_p0, rs2_s_p0;
    logic [XLEN-1:0]  target_p0;
    logic             taken_p0, jump_p0, illegal_p0, accept_p0;
    logic [CNT_W-1:0] free_p0, inflight_p0;

    logic             vld_p1, taken_p1, jump_p1, illegal_p1, pred_taken_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [XLEN-1:0]  pc_p1, target_p1, pred_target_p1, pc_inc_p1;
    logic             misalign_p1;
    entry_t           entry_d_p1;

    logic             vld_p2;
    entry_t           entry_p2;

    entry_t           fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             push, pop;
    entry_t           head;

    // ---- stage 0: operand compare and target generation ----
    assign rs1_s_p0 = in_rs1;
    assign rs2_s_p0 = in_rs2;

    // Decode the op, evaluate the branch condition and form the target.
    always_comb begin
        taken_p0   = 1'b0;
        jump_p0    = 1'b0;
        illegal_p0 = 1'b0;
        target_p0  = in_pc + in_imm;
        case (in_op)
            OP_BEQ:  taken_p0 = (in_rs1 == in_rs2);
            OP_BNE:  taken_p0 = (in_rs1 != in_rs2);
            OP_BLT:  taken_p0 = (rs1_s_p0 <  rs2_s_p0);
            OP_BGE:  taken_p0 = (rs1_s_p0 >= rs2_s_p0);
            OP_BLTU: taken_p0 = (in_rs1 <  in_rs2);
            OP_BGEU: taken_p0 = (in_rs1 >= in_rs2);
            OP_JAL: begin
                taken_p0 = 1'b1;
                jump_p0  = 1'b1;
            end
            OP_JALR: begin
                taken_p0  = 1'b1;
                jump_p0   = 1'b1;
                target_p0 = (in_rs1 + in_imm) & LSB_CLR;
            end
            default: illegal_p0 = 1'b1;
        endcase
    end

    // Credits: free FIFO slots must exceed what is already in s1/s2.
    assign free_p0     = DEPTH_C - fifo_cnt;
    assign inflight_p0 = CNT_W'(vld_p1) + CNT_W'(vld_p2);
    assign ready_o     = !flush_req && (free_p0 > inflight_p0);
    assign accept_p0   = valid_i && ready_o;

    // ---- stage 1: registered compare result and target ----
    // Capture decoded branch state for each accepted instruction.
    always_ff @(posedge clk_core) begin
        if (accept_p0) begin
            tag_p1         <= in_tag;
            pc_p1          <= in_pc;
            target_p1      <= target_p0;
            taken_p1       <= taken_p0;
            jump_p1        <= jump_p0;
            illegal_p1     <= illegal_p0;
            pred_taken_p1  <= in_pred_taken;
            pred_target_p1 <= in_pred_target;
        end
    end

    assign pc_inc_p1   = pc_p1 + XLEN'(4);
    assign misalign_p1 = (MISALIGN_CHECK != 0) && taken_p1 && target_p1[1];

    // Resolve next PC, link and mispredict; exceptions suppress mispredict.
    always_comb begin
        entry_d_p1.tag        = tag_p1;
        entry_d_p1.next_pc    = taken_p1 ? target_p1 : pc_inc_p1;
        entry_d_p1.link       = jump_p1 ? pc_inc_p1 : '0;
        entry_d_p1.taken      = taken_p1;
        entry_d_p1.mispredict = !illegal_p1 && !misalign_p1 &&
                                ((taken_p1 != pred_taken_p1) ||
                                 (taken_p1 && (target_p1 != pred_target_p1)));
        entry_d_p1.exception  = illegal_p1 || misalign_p1;
    end

    // ---- stage 2: resolved result waiting for the FIFO ----
    // Register the resolved entry; it is pushed into the FIFO on the next edge.
    always_ff @(posedge clk_core) begin
        if (vld_p1) begin
            entry_p2 <= entry_d_p1;
        end
    end

    // Pipeline valid bits and flush acknowledge; flush drops everything in flight.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            flush_ack <= 1'b1;
        end else begin
            vld_p1    <= accept_p0 && !flush_req;
            vld_p2    <= vld_p1 && !flush_req;
            flush_ack <= flush_req;
        end
    end

    // ---- output FIFO ----
    assign push    = vld_p2;
    assign valid_o = (fifo_cnt != '0);
    assign pop     = valid_o && ready_i;

    // FIFO pointers and occupancy; a flush empties the FIFO regardless of push/pop.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_req) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; a full FIFO may be written while the head is popped.
    always_ff @(posedge clk_core) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry_p2;
        end
    end

    // Outputs read zero whenever nothing is presented, including after reset.
    assign head           = fifo_mem[rd_ptr];
    assign out_tag        = valid_o ? head.tag        : '0;
    assign out_next_pc    = valid_o ? head.next_pc    : '0;
    assign out_link       = valid_o ? head.link       : '0;
    assign out_taken      = valid_o && head.taken;
    assign out_mispredict = valid_o && head.mispredict;
    assign out_exception  = valid_o && head.exception;

endmodule

// File: doc/hsv_core_branch_unit_param.md
Name: hsv_core_branch_unit_param

Overview:
- Parametrised branch execution unit; successor to the fixed two-substage branch unit.
- Sits between issue and commit. Resolves conditional branches, JAL and JALR, computes next PC and link value, and detects misprediction against the predictor's guess.
- Generalised in data width, tag width and output buffer depth.
- Adds credit-based input backpressure, misprediction detection and misaligned-target exception reporting.

Parameters:
- XLEN, 32, data/address width (32 or 64).
- TAG_W, 5, width of the instruction tag passed through to commit.
- OUT_DEPTH, 2, output FIFO entries (>=2).
- MISALIGN_CHECK, 1, 1 = flag taken targets with bit[1] set as exceptions.

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  asynchronous active-low reset
- flush_req  in  1  pipeline flush request
- flush_ack  out  1  flush acknowledge
- valid_i  in  1  input valid
- ready_o  out  1  input ready
- in_op  in  4  0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU, 8 JAL, 9 JALR; others illegal
- in_pc  in  XLEN  instruction PC
- in_rs1  in  XLEN  operand 1
- in_rs2  in  XLEN  operand 2
- in_imm  in  XLEN  sign-extended immediate
- in_tag  in  TAG_W  instruction tag
- in_pred_taken  in  1  predictor direction
- in_pred_target  in  XLEN  predictor target
- valid_o  out  1  output valid
- ready_i  in  1  commit ready
- out_tag  out  TAG_W  tag
- out_next_pc  out  XLEN  resolved next PC
- out_link  out  XLEN  link value
- out_taken  out  1  resolved direction
- out_mispredict  out  1  predictor wrong
- out_exception  out  1  illegal op or misaligned target

Behaviour:
- Clock and reset:
  - Single clock clk_core; reset is asynchronous, active-low on rst_core_n.
  - Reset clears s1/s2 valid bits and the FIFO, and sets flush_ack=1.
  - After reset: valid_o=0, all out_* data=0, ready_o=1.
- Pipeline:
  - s1 (compare + target) -> s2 (next PC, link, mispredict) -> OUT_DEPTH FIFO.
  - s1 and s2 advance every cycle and never stall.
  - An input accepted at edge E0 reaches s2 at E1, is written to the FIFO at E2, and valid_o is visible after E2 (2-cycle latency when the FIFO is empty).
- Credits:
  - ready_o = (free FIFO entries) > (s1.valid + s2.valid), computed combinationally from registered state.
  - ready_o = 0 while flush_req = 1.
  - Accept = valid_i && ready_o.
- Arithmetic (all modulo 2^XLEN):
  - BLT/BGE compare signed; BLTU/BGEU unsigned.
  - JAL and JALR are always taken.
  - Target = pc+imm for branches and JAL; (rs1+imm) & ~1 for JALR.
  - out_link = pc+4 for JAL/JALR, else 0.
  - out_next_pc = taken ? target : pc+4.
- Misprediction:
  - out_mispredict = (taken != pred_taken) || (taken && target != pred_target).
- Exceptions:
  - Illegal op -> exception=1, taken=0, mispredict=0, next_pc=pc+4.
  - If MISALIGN_CHECK=1, a taken target with bit[1]=1 -> exception=1, mispredict=0; next_pc still holds the target.
- FIFO:
  - Pop when valid_o && ready_i.
  - Push and pop in the same cycle on a full FIFO is legal.
  - Output fields hold steady while valid_o && !ready_i.
  - The credit rule guarantees no overflow; the bench asserts no push occurs when full.
- Flush:
  - On any edge with flush_req=1, s1/s2 valid and the FIFO count clear; valid_o=0 from the next cycle.
  - An input presented during flush is not accepted.
  - flush_ack registers flush_req (1-cycle delay).
  - A flush coinciding with a pop or push: the flush wins and all entries are dropped.

Test Plan:
1. BEQ pc=0x100, rs1=rs2=5, imm=0x20, pred_taken=1, pred_target=0x120 -> after 2 cycles: valid_o=1, taken=1, next_pc=0x120, mispredict=0, link=0.
2. BLT rs1=0xFFFFFFFF, rs2=1 (signed -1<1) vs BLTU with the same operands -> taken=1 vs taken=0; pred_taken=1 on both makes mispredict 0 then 1.
3. JALR pc=0x200, rs1=0x1003, imm=0 -> target 0x1002, link=0x204, exception=1 (MISALIGN_CHECK=1); with MISALIGN_CHECK=0 -> exception=0.
4. OUT_DEPTH=2, ready_i=0, valid_i held high -> exactly 2 accepts, then ready_o=0. Raising ready_i drains entries in order (tags 0,1), then ready_o returns to 1.
5. Three ops in flight, flush_req pulsed 1 cycle -> valid_o=0 the next cycle, no stale outputs later, flush_ack high one cycle after flush_req.
6. rst_core_n asserted mid-stream with the FIFO full -> valid_o=0, flush_ack=1, ready_o=1 immediately (asynchronous).
